alu_core: RTL and testbench

//  Synthesizable ALU datapath: the responder that consumes the OPA/OPB/Cin/mode/inp_valid/CMD

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_datapath.sv | 78 +++++++
 rtl/alu_core.sv | 159 +++++++++++++++
 tb/tb_alu_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared command encodings, FSM states, flag bundle and command classification helpers.
package alu_pkg;

  localparam int unsigned CmdW          = 4;
  localparam int unsigned TimeoutCycles = 16;

  typedef enum logic [3:0] {
    ArAdd    = 4'd0,
    ArSub    = 4'd1,
    ArAddCin = 4'd2,
    ArSubCin = 4'd3,
    ArIncA   = 4'd4,
    ArDecA   = 4'd5,
    ArIncB   = 4'd6,
    ArDecB   = 4'd7,
    ArCmp    = 4'd8
  } arith_cmd_e;

  typedef enum logic [3:0] {
    LgAnd  = 4'd0,
    LgNand = 4'd1,
    LgOr   = 4'd2,
    LgNor  = 4'd3,
    LgXor  = 4'd4,
    LgXnor = 4'd5,
    LgNotA = 4'd6,
    LgNotB = 4'd7,
    LgShrA = 4'd8,
    LgShlA = 4'd9,
    LgShrB = 4'd10,
    LgShlB = 4'd11,
    LgRol  = 4'd12,
    LgRor  = 4'd13
  } logic_cmd_e;

  typedef logic state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StWait = 1'b1;

  typedef struct packed {
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
    logic err;
  } flags_t;

  function automatic logic cmd_illegal(logic mode, logic [CmdW-1:0] cmd);
    return mode ? (cmd > 4'd8) : (cmd > 4'd13);
  endfunction

  // Operand mask a command needs: bit 0 = OPA, bit 1 = OPB.
  function automatic logic [1:0] cmd_need(logic mode, logic [CmdW-1:0] cmd);
    logic [1:0] need;
    need = 2'b11;
    if (mode) begin
      if (cmd == ArIncA || cmd == ArDecA) need = 2'b01;
      if (cmd == ArIncB || cmd == ArDecB) need = 2'b10;
    end else begin
      if (cmd == LgNotA || cmd == LgShrA || cmd == LgShlA) need = 2'b01;
      if (cmd == LgNotB || cmd == LgShrB || cmd == LgShlB) need = 2'b10;
    end
    return need;
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU: operands, command, mode and carry-in to a W+1 bit result and flags.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    opa,
  input  logic [W-1:0]    opb,
  input  logic            cin,
  input  logic            mode,
  input  logic [CmdW-1:0] cmd,
  output logic [W:0]      res,
  output flags_t          flags
);

  localparam int SW = $clog2(W);
  localparam logic [W:0] One = 1;

  logic [W:0]     a, b, c1;
  logic [SW-1:0]  amt;
  logic           rot_bad;
  logic [2*W-1:0] rot_dbl;

  always_comb begin
    a       = {1'b0, opa};
    b       = {1'b0, opb};
    c1      = {{W{1'b0}}, cin};
    amt     = opb[SW-1:0];
    rot_bad = |(opb >> SW);
    rot_dbl = {opa, opa};
    res     = '0;
    flags   = '0;
    if (mode) begin
      case (cmd)
        ArAdd:    begin res = a + b;      flags.cout  = res[W];     end
        ArSub:    begin res = a - b;      flags.oflow = (a < b);    end
        ArAddCin: begin res = a + b + c1; flags.cout  = res[W];     end
        ArSubCin: begin res = a - b - c1; flags.oflow = (a < b + c1); end
        ArIncA:   begin res = a + One;    flags.cout  = res[W];     end
        ArDecA:   begin res = a - One;    flags.oflow = (opa == '0); end
        ArIncB:   begin res = b + One;    flags.cout  = res[W];     end
        ArDecB:   begin res = b - One;    flags.oflow = (opb == '0); end
        ArCmp: begin
          flags.g = (opa > opb);
          flags.l = (opa < opb);
          flags.e = (opa == opb);
        end
        default:  flags.err = 1'b1;
      endcase
    end else begin
      case (cmd)
        LgAnd:  res = {1'b0, opa & opb};
        LgNand: res = {1'b0, ~(opa & opb)};
        LgOr:   res = {1'b0, opa | opb};
        LgNor:  res = {1'b0, ~(opa | opb)};
        LgXor:  res = {1'b0, opa ^ opb};
        LgXnor: res = {1'b0, ~(opa ^ opb)};
        LgNotA: res = {1'b0, ~opa};
        LgNotB: res = {1'b0, ~opb};
        LgShrA: res = {1'b0, opa >> 1};
        LgShlA: res = {1'b0, opa << 1};
        LgShrB: res = {1'b0, opb >> 1};
        LgShlB: res = {1'b0, opb << 1};
        // Rotates read a window out of {opa, opa}; out-of-range amounts flag an error.
        LgRol: begin
          if (rot_bad) flags.err = 1'b1;
          else         res = {1'b0, rot_dbl[(2*W-1-int'(amt)) -: W]};
        end
        LgRor: begin
          if (rot_bad) flags.err = 1'b1;
          else         res = {1'b0, rot_dbl[int'(amt) +: W]};
        end
        default: flags.err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU top: pairs split operands with a timeout FSM and registers results under clock enable.
module alu_core
  import alu_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = TimeoutCycles
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         CE,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         Cin,
  input  logic         mode,
  input  logic [1:0]   inp_valid,
  input  logic [N-1:0] CMD,
  output logic [W:0]   RES,
  output logic         OFLOW,
  output logic         COUT,
  output logic         G,
  output logic         L,
  output logic         E,
  output logic         ERR
);

  localparam int CntW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [1:0]     have_q, have_d;
  logic [N-1:0]   cmd_q, cmd_d;
  logic           mode_q, mode_d, cin_q, cin_d;
  logic [W:0]     res_q, res_d;
  flags_t         flg_q, flg_d;

  logic [W-1:0]   dp_opa, dp_opb;
  logic [N-1:0]   dp_cmd;
  logic           dp_mode, dp_cin, compute;
  logic [1:0]     need;
  logic [W:0]     dp_res;
  flags_t         dp_flags;

  alu_datapath #(.W(W)) u_datapath (
    .opa   (dp_opa),
    .opb   (dp_opb),
    .cin   (dp_cin),
    .mode  (dp_mode),
    .cmd   (dp_cmd),
    .res   (dp_res),
    .flags (dp_flags)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    have_d  = have_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    res_d   = res_q;
    flg_d   = flg_q;
    dp_opa  = OPA;
    dp_opb  = OPB;
    dp_cmd  = CMD;
    dp_mode = mode;
    dp_cin  = Cin;
    compute = 1'b0;
    need    = cmd_need(mode, CMD);
    case (state_q)
      StIdle: begin
        if (inp_valid != 2'b00) begin
          if (cmd_illegal(mode, CMD)) begin
            res_d     = '0;
            flg_d     = '0;
            flg_d.err = 1'b1;
          end else if ((inp_valid & need) == need) begin
            compute = 1'b1;
          end else if (need == 2'b11) begin
            if (inp_valid[0]) opa_d = OPA;
            if (inp_valid[1]) opb_d = OPB;
            have_d  = inp_valid;
            cmd_d   = CMD;
            mode_d  = mode;
            cin_d   = Cin;
            cnt_d   = '0;
            state_d = StWait;
          end
          // A single-operand command offered only the other operand is dropped.
        end
      end
      default: begin
        dp_cmd  = cmd_q;
        dp_mode = mode_q;
        dp_cin  = cin_q;
        dp_opa  = inp_valid[0] ? OPA : opa_q;
        dp_opb  = inp_valid[1] ? OPB : opb_q;
        if ((inp_valid | have_q) == 2'b11) begin
          compute = 1'b1;
          state_d = StIdle;
        end else begin
          if (inp_valid[0]) opa_d = OPA;
          if (inp_valid[1]) opb_d = OPB;
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            res_d     = '0;
            flg_d     = '0;
            flg_d.err = 1'b1;
            cnt_d     = '0;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
    endcase
    if (compute) begin
      res_d = dp_res;
      flg_d = dp_flags;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      have_q  <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      have_q  <= have_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign RES   = res_q;
  assign OFLOW = flg_q.oflow;
  assign COUT  = flg_q.cout;
  assign G     = flg_q.g;
  assign L     = flg_q.l;
  assign E     = flg_q.e;
  assign ERR   = flg_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus random traffic against a cycle model.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst, ce, cin, mode;
  logic [7:0] opa, opb;
  logic [1:0] iv;
  logic [3:0] cmd;
  logic [8:0] RES;
  logic       OFLOW, COUT, G, L, E, ERR;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: expected outputs {RES, OFLOW, COUT, G, L, E, ERR} and pending operand.
  logic [14:0] exp_out;
  bit          pend;
  logic [1:0]  p_have;
  logic [7:0]  pa, pb;
  logic [3:0]  pcmd;
  logic        pmode, pcin;
  int          age;

  alu_core dut (
    .clk       (clk),
    .RST       (rst),
    .CE        (ce),
    .OPA       (opa),
    .OPB       (opb),
    .Cin       (cin),
    .mode      (mode),
    .inp_valid (iv),
    .CMD       (cmd),
    .RES       (RES),
    .OFLOW     (OFLOW),
    .COUT      (COUT),
    .G         (G),
    .L         (L),
    .E         (E),
    .ERR       (ERR)
  );

  always #5 clk = ~clk;

  task automatic ref_alu(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, output logic [14:0] o);
    int r;
    logic of, co, g, l, e, er;
    logic [7:0] t;
    r = 0; of = 0; co = 0; g = 0; l = 0; e = 0; er = 0;
    if (m) begin
      case (c)
        0: begin r = a + b;      co = (r > 255); end
        1: begin r = a - b;      of = (r < 0);   end
        2: begin r = a + b + ci; co = (r > 255); end
        3: begin r = a - b - ci; of = (r < 0);   end
        4: begin r = a + 1;      co = (r > 255); end
        5: begin r = a - 1;      of = (r < 0);   end
        6: begin r = b + 1;      co = (r > 255); end
        7: begin r = b - 1;      of = (r < 0);   end
        8: begin g = (a > b); l = (a < b); e = (a == b); end
        default: er = 1;
      endcase
    end else begin
      case (c)
        0:  r = a & b;
        1:  begin t = ~(a & b); r = t; end
        2:  r = a | b;
        3:  begin t = ~(a | b); r = t; end
        4:  r = a ^ b;
        5:  begin t = ~(a ^ b); r = t; end
        6:  begin t = ~a; r = t; end
        7:  begin t = ~b; r = t; end
        8:  r = a >> 1;
        9:  begin t = a << 1; r = t; end
        10: r = b >> 1;
        11: begin t = b << 1; r = t; end
        12, 13: begin
          if (b > 7) er = 1;
          else begin
            t = a;
            for (int k = 0; k < int'(b); k++)
              t = (c == 12) ? {t[6:0], t[7]} : {t[0], t[7:1]};
            r = t;
          end
        end
        default: er = 1;
      endcase
    end
    o = {r[8:0], of, co, g, l, e, er};
  endtask

  task automatic model_reset();
    exp_out = '0;
    pend    = 0;
    age     = 0;
  endtask

  // Applies the pairing rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic sa, sb;
    if (!rst || !ce) return;
    if (!pend) begin
      if (iv != 2'b00) begin
        sa = mode ? (cmd == 4 || cmd == 5) : (cmd == 6 || cmd == 8 || cmd == 9);
        sb = mode ? (cmd == 6 || cmd == 7) : (cmd == 7 || cmd == 10 || cmd == 11);
        if (mode ? (cmd > 8) : (cmd > 13)) exp_out = 15'd1;
        else if (sa || sb) begin
          if ((sa && iv[0]) || (sb && iv[1])) ref_alu(mode, cmd, opa, opb, cin, exp_out);
        end else if (iv == 2'b11) ref_alu(mode, cmd, opa, opb, cin, exp_out);
        else begin
          pend = 1; p_have = iv; pa = opa; pb = opb;
          pcmd = cmd; pmode = mode; pcin = cin; age = 0;
        end
      end
    end else begin
      if ((iv | p_have) == 2'b11) begin
        ref_alu(pmode, pcmd, iv[0] ? opa : pa, iv[1] ? opb : pb, pcin, exp_out);
        pend = 0;
      end else begin
        if (iv[0]) pa = opa;
        if (iv[1]) pb = opb;
        age++;
        if (age == 16) begin
          exp_out = 15'd1;
          pend    = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [14:0] obs;
    obs = {RES, OFLOW, COUT, G, L, E, ERR};
    n_assert++;
    assert (obs === exp_out) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_out);
    end
  endtask

  task automatic check_const(input string tag, input logic [14:0] want);
    logic [14:0] obs;
    obs = {RES, OFLOW, COUT, G, L, E, ERR};
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic set(input logic [1:0] v, input logic m, input logic [3:0] c,
                     input logic [7:0] a, input logic [7:0] b, input logic ci);
    iv = v; mode = m; cmd = c; opa = a; opb = b; cin = ci;
  endtask

  task automatic beat(input string tag, input logic [1:0] v, input logic m,
                      input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic ci);
    set(v, m, c, a, b, ci);
    tick(tag);
  endtask

  initial begin
    rst = 1'b0;
    ce  = 1'b1;
    set(2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    model_reset();
    #1;
    check_const("reset_outputs", 15'd0);
    @(posedge clk);
    #3 rst = 1'b1;

    beat("add_ff_01", 2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    check_const("add_ff_01_k", {9'h100, 6'b010000});

    beat("cmp_05_09", 2'b11, 1'b1, 4'd8, 8'h05, 8'h09, 1'b0);
    check_const("cmp_05_09_k", {9'h000, 6'b000100});

    ce = 1'b0;
    beat("ce_freeze", 2'b11, 1'b1, 4'd0, 8'h01, 8'h02, 1'b0);
    check_const("ce_freeze_k", {9'h000, 6'b000100});
    ce = 1'b1;

    beat("split_a", 2'b01, 1'b1, 4'd0, 8'h03, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) beat("split_idle", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    beat("split_b", 2'b10, 1'b0, 4'd15, 8'h00, 8'h04, 1'b0);
    check_const("split_k", {9'h007, 6'b000000});

    beat("to_a", 2'b01, 1'b1, 4'd0, 8'h11, 8'h00, 1'b0);
    for (int k = 0; k < 15; k++) beat("to_wait", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    check_const("to_not_yet", {9'h007, 6'b000000});
    beat("to_fire", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    check_const("to_fire_k", 15'd1);

    beat("to_clear", 2'b11, 1'b1, 4'd0, 8'h01, 8'h01, 1'b0);
    beat("toce_a", 2'b01, 1'b1, 4'd0, 8'h22, 8'h00, 1'b0);
    for (int k = 0; k < 18; k++) begin
      ce = !(k >= 5 && k < 8);
      beat("toce_wait", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    end
    ce = 1'b1;
    check_const("toce_not_yet", {9'h002, 6'b000000});
    beat("toce_fire", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    check_const("toce_fire_k", 15'd1);

    beat("rol_81_1", 2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0);
    check_const("rol_81_1_k", {9'h003, 6'b000000});
    beat("rol_bad", 2'b11, 1'b0, 4'd12, 8'h81, 8'h10, 1'b0);
    check_const("rol_bad_k", 15'd1);
    beat("illegal_arith", 2'b01, 1'b1, 4'd9, 8'h05, 8'h05, 1'b0);
    beat("dec_a_zero", 2'b01, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
    check_const("dec_a_zero_k", {9'h1FF, 6'b100000});

    beat("rst_wait_a", 2'b01, 1'b1, 4'd0, 8'h09, 8'h00, 1'b0);
    beat("rst_wait_idle", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_const("rst_async", 15'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    beat("sub_02_05", 2'b11, 1'b1, 4'd1, 8'h02, 8'h05, 1'b0);
    check_const("sub_02_05_k", {9'h1FD, 6'b100000});

    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 4))
        0, 1:    iv = 2'b00;
        2:       iv = 2'b01;
        3:       iv = 2'b10;
        default: iv = 2'b11;
      endcase
      mode = 1'($urandom_range(0, 1));
      cmd  = 4'($urandom_range(0, 15));
      opa  = 8'($urandom);
      opb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      cin  = 1'($urandom_range(0, 1));
      tick($sformatf("rand_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
